// File: rtl/noc_inject_arbiter_if.sv
// rtl/noc_inject_arbiter_if.sv - requester and router-endpoint signals of the injection arbiter
interface noc_inject_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DEST_WIDTH = 4,
    parameter int FLIT_WIDTH = 256
);
    logic [NUM_REQ-1:0][FLIT_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0][DEST_WIDTH-1:0] req_dest;
    logic [NUM_REQ-1:0]                 req_is_tail;
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [FLIT_WIDTH-1:0]              data_out;
    logic [DEST_WIDTH-1:0]              dest_out;
    logic                               is_tail_out;
    logic                               send_out;
    logic                               credit_in;

    // Arbiter side: consumes requester flits and router credits, drives the endpoint
    modport slave (
        input  req_data, req_dest, req_is_tail, req_valid, credit_in,
        output req_ready, data_out, dest_out, is_tail_out, send_out
    );

    // Environment side: requesters plus the router model
    modport master (
        output req_data, req_dest, req_is_tail, req_valid, credit_in,
        input  req_ready, data_out, dest_out, is_tail_out, send_out
    );
endinterface

// File: rtl/noc_inject_arbiter.sv
// rtl/noc_inject_arbiter.sv - packet-atomic round-robin injection arbiter with credit flow control
module noc_inject_arbiter #(
    parameter int  NUM_REQ           = 4,
    parameter int  DEST_WIDTH        = 4,
    parameter int  FLIT_WIDTH        = 256,
    parameter int  FLIT_BUFFER_DEPTH = 2,
    localparam int CW                = $clog2(FLIT_BUFFER_DEPTH + 1),
    localparam int IW                = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    noc_inject_arbiter_if.slave   bus,
    output logic [CW-1:0]         credits,
    output logic                  err_credit_overflow
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         rr_q, rr_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [CW-1:0]         credits_q, credits_d;
    logic                  err_q, err_d;
    logic                  send_q;
    logic [FLIT_WIDTH-1:0] data_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic                  tail_q;

    logic                  found;
    logic [IW-1:0]         win;
    logic [IW-1:0]         sel;
    logic                  accept;
    logic [NUM_REQ-1:0]    ready;
    logic                  have_credit;
    logic                  credits_full;

    function automatic logic [IW-1:0] rr_after(input logic [IW-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    assign have_credit  = (credits_q != '0);
    assign credits_full = (credits_q == CW'(FLIT_BUFFER_DEPTH));

    // First valid requester at or after rr, wrapping
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_v;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_v = IW'(idx);
            if (!found && bus.req_valid[idx_v]) begin
                found = 1'b1;
                win   = idx_v;
            end
        end
    end

    // Grant FSM: choose a ready line, decide on lock and rr advance
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        ready   = '0;
        accept  = 1'b0;
        sel     = owner_q;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (found && have_credit) begin
                        ready[win] = 1'b1;
                        accept     = 1'b1;
                        sel        = win;
                        if (bus.req_is_tail[win]) begin
                            rr_d = rr_after(win);
                        end else begin
                            state_d = LOCKED;
                            owner_d = win;
                        end
                    end
                end
                LOCKED: begin
                    if (bus.req_valid[owner_q] && have_credit) begin
                        ready[owner_q] = 1'b1;
                        accept         = 1'b1;
                        if (bus.req_is_tail[owner_q]) begin
                            state_d = IDLE;
                            rr_d    = rr_after(owner_q);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Credit accounting; a credit returned into a full counter is flagged, not counted
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        case ({accept, bus.credit_in})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01: begin
                if (credits_full) err_d = 1'b1;
                else              credits_d = credits_q + 1'b1;
            end
            default: credits_d = credits_q;
        endcase
    end

    // State, pointer and credit registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            owner_q   <= '0;
            credits_q <= CW'(FLIT_BUFFER_DEPTH);
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    // Registered injection port; payload holds while nothing is sent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_q <= 1'b0;
            data_q <= '0;
            dest_q <= '0;
            tail_q <= 1'b0;
        end else begin
            send_q <= accept;
            if (accept) begin
                data_q <= bus.req_data[sel];
                dest_q <= bus.req_dest[sel];
                tail_q <= bus.req_is_tail[sel];
            end
        end
    end

    assign bus.req_ready       = ready;
    assign bus.send_out        = send_q;
    assign bus.data_out        = data_q;
    assign bus.dest_out        = dest_q;
    assign bus.is_tail_out     = tail_q;
    assign credits             = credits_q;
    assign err_credit_overflow = err_q;
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb/tb_noc_inject_arbiter.sv - directed self-checking bench for noc_inject_arbiter
module tb_noc_inject_arbiter;
    localparam int NR    = 4;
    localparam int DW    = 4;
    localparam int FW    = 256;
    localparam int DEPTH = 2;

    localparam logic [FW-1:0] DA = {8{32'hA5A5_0001}};
    localparam logic [FW-1:0] DB = {8{32'hB0B0_0100}};
    localparam logic [FW-1:0] DC = {8{32'hC3C3_1000}};
    localparam logic [FW-1:0] DE = {8{32'hE1E1_7777}};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] credits;
    logic       err;
    int         vec_cnt = 0;
    int         err_cnt = 0;

    noc_inject_arbiter_if #(.NUM_REQ(NR), .DEST_WIDTH(DW), .FLIT_WIDTH(FW)) bus ();

    noc_inject_arbiter #(
        .NUM_REQ(NR), .DEST_WIDTH(DW), .FLIT_WIDTH(FW), .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
        .credits(credits),
        .err_credit_overflow(err)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [DW-1:0] d, input logic t, input logic [FW-1:0] data);
        bus.req_dest[i]    = d;
        bus.req_is_tail[i] = t;
        bus.req_data[i]    = data;
    endtask

    task automatic clear_inputs();
        bus.req_valid   = '0;
        bus.req_is_tail = '0;
        bus.req_dest    = '0;
        bus.req_data    = '0;
        bus.credit_in   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.req_valid = 4'hF;
        @(negedge clk);
        #1;
        vec_cnt++; if (bus.req_ready !== 4'h0) begin err_cnt++; $display("FAIL rst_ready: got %b expected 0000", bus.req_ready); end
        vec_cnt++; if (bus.send_out !== 1'b0) begin err_cnt++; $display("FAIL rst_send: got %b expected 0", bus.send_out); end
        vec_cnt++; if (bus.data_out !== '0) begin err_cnt++; $display("FAIL rst_data: got %h expected 0", bus.data_out); end
        vec_cnt++; if (bus.dest_out !== 4'h0 || bus.is_tail_out !== 1'b0) begin err_cnt++; $display("FAIL rst_dest_tail: got %h/%b expected 0/0", bus.dest_out, bus.is_tail_out); end
        vec_cnt++; if (credits !== 2'd2) begin err_cnt++; $display("FAIL rst_credits: got %0d expected 2", credits); end
        vec_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL rst_err: got %b expected 0", err); end
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_flit();
        #1;
        vec_cnt++; if (bus.req_ready !== 4'h0) begin err_cnt++; $display("FAIL idle_ready: got %b expected 0000", bus.req_ready); end
        set_req(2, 4'd3, 1'b1, DA);
        bus.req_valid = 4'b0100;
        #1;
        vec_cnt++; if (bus.req_ready !== 4'b0100) begin err_cnt++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
        @(negedge clk);
        vec_cnt++; if (bus.send_out !== 1'b1 || bus.dest_out !== 4'd3 || bus.is_tail_out !== 1'b1) begin err_cnt++; $display("FAIL single_out: got send=%b dest=%0d tail=%b expected 1/3/1", bus.send_out, bus.dest_out, bus.is_tail_out); end
        vec_cnt++; if (bus.data_out !== DA) begin err_cnt++; $display("FAIL single_data: got %h expected %h", bus.data_out, DA); end
        vec_cnt++; if (credits !== 2'd1) begin err_cnt++; $display("FAIL single_credits: got %0d expected 1", credits); end
        bus.req_valid = '0;
        @(negedge clk);
        vec_cnt++; if (bus.send_out !== 1'b0 || bus.dest_out !== 4'd3 || bus.data_out !== DA) begin err_cnt++; $display("FAIL single_hold: got send=%b dest=%0d expected 0/3 with data held", bus.send_out, bus.dest_out); end
        bus.credit_in = 1'b1;
        @(negedge clk);
        bus.credit_in = 1'b0;
        vec_cnt++; if (credits !== 2'd2) begin err_cnt++; $display("FAIL single_credit_return: got %0d expected 2", credits); end
    endtask

    task automatic test_atomicity();
        set_req(1, 4'd9, 1'b1, DE);
        bus.req_valid = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            set_req(0, 4'd5, (k == 2), DB + FW'(k));
            #1;
            vec_cnt++; if (bus.req_ready !== 4'b0001) begin err_cnt++; $display("FAIL atom_ready[%0d]: got %b expected 0001", k, bus.req_ready); end
            @(negedge clk);
            bus.credit_in = 1'b1;
            vec_cnt++; if (bus.send_out !== 1'b1 || bus.data_out !== DB + FW'(k) || bus.is_tail_out !== (k == 2)) begin err_cnt++; $display("FAIL atom_flit[%0d]: got send=%b tail=%b data=%h", k, bus.send_out, bus.is_tail_out, bus.data_out); end
        end
        bus.req_valid = 4'b0010;
        #1;
        vec_cnt++; if (bus.req_ready !== 4'b0010) begin err_cnt++; $display("FAIL atom_next_ready: got %b expected 0010", bus.req_ready); end
        @(negedge clk);
        vec_cnt++; if (bus.send_out !== 1'b1 || bus.data_out !== DE || bus.dest_out !== 4'd9) begin err_cnt++; $display("FAIL atom_next_flit: got send=%b dest=%0d data=%h", bus.send_out, bus.dest_out, bus.data_out); end
        bus.req_valid = '0;
        @(negedge clk);
        bus.credit_in = 1'b0;
        vec_cnt++; if (credits !== 2'd2) begin err_cnt++; $display("FAIL atom_credits: got %0d expected 2", credits); end
    endtask

    task automatic test_round_robin();
        int cnt [NR];
        logic [NR-1:0] exp_rdy;
        for (int i = 0; i < NR; i++) begin
            cnt[i] = 0;
            set_req(i, DW'(i), 1'b1, FW'(i));
        end
        bus.req_valid = 4'hF;
        bus.credit_in = 1'b1;
        for (int k = 0; k < 100; k++) begin
            #1;
            exp_rdy = NR'(1) << (k % NR);
            vec_cnt++; if (bus.req_ready !== exp_rdy) begin err_cnt++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.req_ready, exp_rdy); end
            for (int i = 0; i < NR; i++) if (bus.req_ready[i] === 1'b1) cnt[i]++;
            @(negedge clk);
        end
        bus.req_valid = '0;
        bus.credit_in = 1'b0;
        for (int i = 0; i < NR; i++) begin
            vec_cnt++; if (cnt[i] < 24 || cnt[i] > 26) begin err_cnt++; $display("FAIL rr_share[%0d]: got %0d expected 24..26", i, cnt[i]); end
        end
        vec_cnt++; if (credits !== 2'd2 || err !== 1'b0) begin err_cnt++; $display("FAIL rr_credits: got credits=%0d err=%b expected 2/0", credits, err); end
    endtask

    task automatic test_credit_exhaustion();
        set_req(0, 4'd1, 1'b1, DC);
        bus.req_valid = 4'b0001;
        #1;
        vec_cnt++; if (bus.req_ready !== 4'b0001) begin err_cnt++; $display("FAIL exh_c0_ready: got %b expected 0001", bus.req_ready); end
        @(negedge clk); #1;
        vec_cnt++; if (bus.send_out !== 1'b1 || credits !== 2'd1 || bus.req_ready !== 4'b0001) begin err_cnt++; $display("FAIL exh_c1: got send=%b credits=%0d ready=%b expected 1/1/0001", bus.send_out, credits, bus.req_ready); end
        @(negedge clk); #1;
        vec_cnt++; if (bus.send_out !== 1'b1 || credits !== 2'd0 || bus.req_ready !== 4'b0000) begin err_cnt++; $display("FAIL exh_c2: got send=%b credits=%0d ready=%b expected 1/0/0000", bus.send_out, credits, bus.req_ready); end
        @(negedge clk); #1;
        vec_cnt++; if (bus.send_out !== 1'b0 || bus.req_ready !== 4'b0000) begin err_cnt++; $display("FAIL exh_c3: got send=%b ready=%b expected 0/0000", bus.send_out, bus.req_ready); end
        @(negedge clk);
        bus.credit_in = 1'b1;
        @(negedge clk);
        bus.credit_in = 1'b0;
        #1;
        vec_cnt++; if (credits !== 2'd1 || bus.req_ready !== 4'b0001) begin err_cnt++; $display("FAIL exh_c5: got credits=%0d ready=%b expected 1/0001", credits, bus.req_ready); end
        @(negedge clk);
        bus.credit_in = 1'b1;
        #1;
        vec_cnt++; if (bus.send_out !== 1'b1 || credits !== 2'd0 || bus.req_ready !== 4'b0000) begin err_cnt++; $display("FAIL exh_c6: got send=%b credits=%0d ready=%b expected 1/0/0000", bus.send_out, credits, bus.req_ready); end
        @(negedge clk); #1;
        vec_cnt++; if (bus.send_out !== 1'b0 || credits !== 2'd1 || bus.req_ready !== 4'b0001) begin err_cnt++; $display("FAIL exh_c7: got send=%b credits=%0d ready=%b expected 0/1/0001", bus.send_out, credits, bus.req_ready); end
        @(negedge clk);
        vec_cnt++; if (bus.send_out !== 1'b1 || credits !== 2'd1) begin err_cnt++; $display("FAIL exh_simul: got send=%b credits=%0d expected 1/1", bus.send_out, credits); end
        bus.req_valid = '0;
        @(negedge clk);
        bus.credit_in = 1'b0;
        vec_cnt++; if (credits !== 2'd2) begin err_cnt++; $display("FAIL exh_refill: got %0d expected 2", credits); end
    endtask

    task automatic test_overflow();
        bus.credit_in = 1'b1;
        @(negedge clk);
        bus.credit_in = 1'b0;
        vec_cnt++; if (credits !== 2'd2 || err !== 1'b1) begin err_cnt++; $display("FAIL ovf_set: got credits=%0d err=%b expected 2/1", credits, err); end
        repeat (3) @(negedge clk);
        vec_cnt++; if (err !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky: got %b expected 1", err); end
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (err !== 1'b0 || credits !== 2'd2) begin err_cnt++; $display("FAIL ovf_clear: got err=%b credits=%0d expected 0/2", err, credits); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_packet();
        set_req(1, 4'd2, 1'b1, DA);
        bus.req_valid = 4'b0010;
        #1;
        vec_cnt++; if (bus.req_ready !== 4'b0010) begin err_cnt++; $display("FAIL midrst_pre_ready: got %b expected 0010", bus.req_ready); end
        @(negedge clk);
        set_req(3, 4'd7, 1'b0, DB);
        bus.req_valid = 4'b1000;
        #1;
        vec_cnt++; if (bus.req_ready !== 4'b1000) begin err_cnt++; $display("FAIL midrst_head_ready: got %b expected 1000", bus.req_ready); end
        @(negedge clk);
        vec_cnt++; if (bus.send_out !== 1'b1 || bus.data_out !== DB) begin err_cnt++; $display("FAIL midrst_head_out: got send=%b data=%h", bus.send_out, bus.data_out); end
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (bus.send_out !== 1'b0 || bus.data_out !== '0 || bus.req_ready !== 4'b0000) begin err_cnt++; $display("FAIL midrst_async: got send=%b ready=%b data=%h expected 0/0000/0", bus.send_out, bus.req_ready, bus.data_out); end
        @(negedge clk);
        rst_n = 1'b1;
        set_req(1, 4'd4, 1'b1, DC);
        bus.req_valid = 4'b1010;
        #1;
        vec_cnt++; if (bus.req_ready !== 4'b0010) begin err_cnt++; $display("FAIL midrst_after_ready: got %b expected 0010", bus.req_ready); end
        @(negedge clk);
        vec_cnt++; if (bus.send_out !== 1'b1 || bus.data_out !== DC || bus.dest_out !== 4'd4) begin err_cnt++; $display("FAIL midrst_after_out: got send=%b dest=%0d data=%h", bus.send_out, bus.dest_out, bus.data_out); end
        bus.req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_atomicity();
        do_reset();
        test_round_robin();
        do_reset();
        test_credit_exhaustion();
        test_overflow();
        do_reset();
        test_reset_mid_packet();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
